axil_mac_master: RTL and testbench

AXI4-Lite master that fetches two operands from slave memory, multiplies them and writes the product back to a third address, all triggered by a single `start` pulse. It replaces the hard-coded 16-bit multiply master with a single protocol-correct FSM. It adds parametrised widths, optional signed arithmetic, response-error reporting and an optional accumulate mode. It sits between the control register block and the AXI4-Lite interconnect.

---
 rtl/axil_mac_pkg.sv | 21 ++
 rtl/axil_mac_master_mac.sv | 54 +++++
 rtl/axil_mac_master.sv | 196 +++++++++++++++++++
 tb/tb_axil_mac_master.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mac_pkg.sv
// Shared types for the AXI4-Lite multiply/accumulate master.
// Optional accumulate mode is enabled with AXIL_MAC_ACCUM_EN.
package axil_mac_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_AR_A,
        S_R_A,
        S_AR_B,
        S_R_B,
        S_MUL,
        S_WR,
        S_B,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_mac_master_mac.sv
// Registered multiply (or multiply-accumulate with AXIL_MAC_ACCUM_EN).
// Operands are extended to full product width so the truncated product wraps.
module mac_unit #(
    parameter int OP_W   = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic                PCLK,
    input  logic                PRESET,
`ifdef AXIL_MAC_ACCUM_EN
    input  logic                clr_i,
`endif
    input  logic                en_i,
    input  logic [OP_W-1:0]     a_i,
    input  logic [OP_W-1:0]     b_i,
    output logic [2*OP_W-1:0]   result_o
);

    localparam int PW = 2 * OP_W;

    logic [PW-1:0] a_x;
    logic [PW-1:0] b_x;
    logic [PW-1:0] prod;
    logic [PW-1:0] result_q;
    logic [PW-1:0] result_d;

    always_comb begin
        a_x      = {{OP_W{SIGNED & a_i[OP_W-1]}}, a_i};
        b_x      = {{OP_W{SIGNED & b_i[OP_W-1]}}, b_i};
        prod     = a_x * b_x;
        result_d = result_q;
`ifdef AXIL_MAC_ACCUM_EN
        if (clr_i) begin
            result_d = '0;
        end else if (en_i) begin
            result_d = result_q + prod;
        end
`else
        if (en_i) begin
            result_d = prod;
        end
`endif
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/axil_mac_master.sv
// AXI4-Lite master: read two operands, multiply, write the product back.
// Define AXIL_MAC_ACCUM_EN for accumulate mode and the acc_clr port.
module axil_mac_master
    import axil_mac_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OP_W   = 16,
    parameter int SIGNED = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
`ifdef AXIL_MAC_ACCUM_EN
    input  logic                acc_clr,
`endif
    input  logic                start,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    input  logic [ADDR_W-1:0]   waddr,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2*OP_W-1:0]   result,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    state_t              state_q, state_d;
    logic                flag_q, flag_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [ADDR_W-1:0]   baddr_q, baddr_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [OP_W-1:0]     opa_q, opa_d;
    logic [OP_W-1:0]     opb_q, opb_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                rresp_bad;
    logic [2*OP_W-1:0]   result_w;
    logic                unused_rdata;

    assign rresp_bad    = (rresp != RESP_OKAY);
    assign unused_rdata = ^rdata[DATA_W-1:OP_W];

    always_comb begin
        state_d  = state_q;
        flag_d   = flag_q;
        araddr_d = araddr_q;
        baddr_d  = baddr_q;
        awaddr_d = awaddr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_AR_A;
                    flag_d   = 1'b0;
                    araddr_d = raddr_a;
                    baddr_d  = raddr_b;
                    awaddr_d = waddr;
                end
            end
            S_AR_A: if (arready) state_d = S_R_A;
            S_R_A: begin
                if (rvalid) begin
                    opa_d    = rdata[OP_W-1:0];
                    flag_d   = flag_q | rresp_bad;
                    araddr_d = baddr_q;
                    state_d  = S_AR_B;
                end
            end
            S_AR_B: if (arready) state_d = S_R_B;
            S_R_B: begin
                if (rvalid) begin
                    opb_d   = rdata[OP_W-1:0];
                    flag_d  = flag_q | rresp_bad;
                    state_d = (flag_q | rresp_bad) ? S_DONE : S_MUL;
                end
            end
            S_MUL: state_d = S_WR;
            S_WR: begin
                if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    flag_d  = flag_q | (bresp != RESP_OKAY);
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state, so no AXI input
        // reaches an AXI output without passing through a flop.
        arvalid_d = (state_d == S_AR_A) || (state_d == S_AR_B);
        rready_d  = (state_d == S_R_A) || (state_d == S_R_B);
        awvalid_d = (state_q == S_MUL) ||
                    ((state_q == S_WR) && awvalid_q && !awready);
        wvalid_d  = (state_q == S_MUL) ||
                    ((state_q == S_WR) && wvalid_q && !wready);
        bready_d  = (state_d == S_B);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        err_d     = done_d & flag_d;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            flag_q    <= 1'b0;
            araddr_q  <= '0;
            baddr_q   <= '0;
            awaddr_q  <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            araddr_q  <= araddr_d;
            baddr_q   <= baddr_d;
            awaddr_q  <= awaddr_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    mac_unit #(
        .OP_W   (OP_W),
        .SIGNED (SIGNED != 0)
    ) u_mac (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
`ifdef AXIL_MAC_ACCUM_EN
        .clr_i    (acc_clr && (state_q == S_IDLE)),
`endif
        .en_i     (state_q == S_MUL),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .result_o (result_w)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign result  = result_w;
    assign araddr  = araddr_q;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;
    assign awaddr  = awaddr_q;
    assign awvalid = awvalid_q;
    assign wvalid  = wvalid_q;
    assign bready  = bready_q;
    assign wstrb   = '1;
    assign wdata   = (SIGNED != 0) ? DATA_W'($signed(result_w))
                                   : DATA_W'(result_w);

endmodule

// File: tb/tb_axil_mac_master.sv
// Bench for axil_mac_master: unsigned and signed instances share one slave.
// Expectations are queued at start and retired when done pulses.
module tb_axil_mac_master;
    import axil_mac_pkg::*;

    logic        PCLK;
    logic        PRESET;
    logic        acc_clr;
    logic        start;
    logic [31:0] raddr_a, raddr_b, waddr;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    logic        busy, done, err, arvalid, rready, awvalid, wvalid, bready;
    logic [31:0] result, araddr, awaddr, wdata;
    logic [3:0]  wstrb;

    logic        s_busy, s_done, s_err, s_arvalid, s_rready;
    logic        s_awvalid, s_wvalid, s_bready;
    logic [31:0] s_result, s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;

    axil_mac_master #(.SIGNED(0)) u_dut (
        .PCLK(PCLK), .PRESET(PRESET),
`ifdef AXIL_MAC_ACCUM_EN
        .acc_clr(acc_clr),
`endif
        .start(start), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .waddr(waddr), .busy(busy), .done(done), .err(err),
        .result(result), .araddr(araddr), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(rready), .awaddr(awaddr),
        .awvalid(awvalid), .awready(awready), .wdata(wdata),
        .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    axil_mac_master #(.SIGNED(1)) u_sgn (
        .PCLK(PCLK), .PRESET(PRESET),
`ifdef AXIL_MAC_ACCUM_EN
        .acc_clr(acc_clr),
`endif
        .start(start), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .waddr(waddr), .busy(s_busy), .done(s_done), .err(s_err),
        .result(s_result), .araddr(s_araddr), .arvalid(s_arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp),
        .rvalid(rvalid), .rready(s_rready), .awaddr(s_awaddr),
        .awvalid(s_awvalid), .awready(awready), .wdata(s_wdata),
        .wstrb(s_wstrb), .wvalid(s_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(s_bready)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] ru;
        logic [31:0] rs;
        bit          e;
        int          lat;
        logic [31:0] wa;
    } exp_t;

    exp_t        sb[$];
    int          n_err = 0;
    int          n_chk = 0;
    logic [31:0] mem [0:63];
    logic [31:0] acc_u, acc_s;

    logic [31:0] rerr_addr, ar_hold_addr;
    int          ar_hold, aw_hold, w_hold;
    int          aw_num;
    bit          ar_bad;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave: reacts on the falling edge, seen by the DUT at the next rise.
    initial begin
        int          ar_left, aw_left, w_left;
        bit          ar_act, aw_act, w_act, aw_got, w_got;
        logic [31:0] ar_addr_l, aw_addr_l, w_data_l;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[4]  = 32'h0000_0003;
        mem[5]  = 32'h0000_0005;
        mem[12] = 32'hDEAD_FFFF;
        mem[13] = 32'h0000_0002;
        mem[16] = 32'h0000_FFFF;
        mem[17] = 32'h0000_FFFF;
        arready = 0; rvalid = 0; rdata = '0; rresp = RESP_OKAY;
        awready = 0; wready = 0; bvalid = 0; bresp = RESP_OKAY;
        ar_left = 0; aw_left = 0; w_left = 0;
        ar_act = 0; aw_act = 0; w_act = 0; aw_got = 0; w_got = 0;
        ar_addr_l = '0; aw_addr_l = '0; w_data_l = '0;
        aw_num = 0; ar_bad = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                arready = 0; rvalid = 0; awready = 0; wready = 0;
                bvalid = 0; ar_act = 0; aw_act = 0; w_act = 0;
                aw_got = 0; w_got = 0;
            end else begin
                if (rvalid) rvalid = 0;
                if (arready) begin
                    arready = 0;
                    rvalid  = 1;
                    rdata   = mem[ar_addr_l[7:2]];
                    rresp   = (ar_addr_l == rerr_addr) ? RESP_SLVERR
                                                       : RESP_OKAY;
                end else if (arvalid) begin
                    if (!ar_act) begin
                        ar_act    = 1;
                        ar_left   = (araddr == ar_hold_addr) ? ar_hold : 0;
                        ar_addr_l = araddr;
                    end else if (araddr != ar_addr_l) begin
                        ar_bad = 1;
                    end
                    if (ar_left > 0) ar_left--;
                    else begin
                        arready = 1;
                        ar_act  = 0;
                    end
                end else if (ar_act) begin
                    ar_bad = 1;
                end
                if (awready) begin
                    awready = 0;
                    aw_got  = 1;
                end else if (awvalid && !aw_got) begin
                    if (!aw_act) begin
                        aw_act  = 1;
                        aw_left = aw_hold;
                    end
                    if (aw_left > 0) aw_left--;
                    else begin
                        awready   = 1;
                        aw_act    = 0;
                        aw_addr_l = awaddr;
                        aw_num++;
                    end
                end
                if (wready) begin
                    wready = 0;
                    w_got  = 1;
                end else if (wvalid && !w_got) begin
                    if (!w_act) begin
                        w_act  = 1;
                        w_left = w_hold;
                    end
                    if (w_left > 0) w_left--;
                    else begin
                        wready   = 1;
                        w_act    = 0;
                        w_data_l = wdata;
                    end
                end
                if (bvalid) bvalid = 0;
                else if (aw_got && w_got) begin
                    mem[aw_addr_l[7:2]] = w_data_l;
                    bvalid = 1;
                    bresp  = RESP_OKAY;
                    aw_got = 0;
                    w_got  = 0;
                end
            end
        end
    end

    task automatic run(input logic [31:0] aa, input logic [31:0] ab,
                       input logic [31:0] wa, input int elat,
                       input bit eerr, input bit poke, input bit clr);
        exp_t        e;
        logic [15:0] a, b;
        logic [31:0] pu, ps;
        int          lat, n0;
        bit          got;
        a  = mem[aa[7:2]][15:0];
        b  = mem[ab[7:2]][15:0];
        pu = 32'(a) * 32'(b);
        ps = int'(shortint'(a)) * int'(shortint'(b));
        if (clr) begin
            acc_u = '0;
            acc_s = '0;
        end
        if (!eerr) begin
`ifdef AXIL_MAC_ACCUM_EN
            acc_u = acc_u + pu;
            acc_s = acc_s + ps;
`else
            acc_u = pu;
            acc_s = ps;
`endif
        end
        e.ru = acc_u; e.rs = acc_s; e.e = eerr; e.lat = elat; e.wa = wa;
        sb.push_back(e);
        n0 = aw_num;
        @(negedge PCLK);
        raddr_a = aa; raddr_b = ab; waddr = wa;
        start = 1; acc_clr = clr;
        @(posedge PCLK); #1;
        start = 0; acc_clr = 0;
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(posedge PCLK); #1;
            lat++;
            if (poke) begin
                start   = (lat == 3);
                raddr_a = 32'h0000_0040;
            end
            if (done) got = 1;
        end
        start = 0;
        e = sb.pop_front();
        chk("done_seen", got, 1);
        chk("latency", lat + 1, e.lat);
        chk("err", err, e.e);
        chk("result", result, e.ru);
        chk("sgn_done_err_res", {s_done, s_err, s_result}, {1'b1, e.e, e.rs});
        chk("aw_count", aw_num - n0, e.e ? 0 : 1);
        if (!e.e) chk("wmem", mem[e.wa[7:2]], e.ru);
        @(posedge PCLK); #1;
        chk("idle_after", {busy, done, err}, 0);
    endtask

    initial begin
        int n;
        PRESET = 1; start = 0; acc_clr = 0;
        raddr_a = '0; raddr_b = '0; waddr = '0;
        rerr_addr = '1; ar_hold_addr = '1;
        ar_hold = 0; aw_hold = 0; w_hold = 0;
        acc_u = '0; acc_s = '0;
        #12;
        chk("rst_ctl", {busy, done, err}, 0);
        chk("rst_axi", {arvalid, rready, awvalid, wvalid, bready}, 0);
        chk("rst_addr", {araddr, awaddr}, 0);
        chk("rst_res", {result, wdata}, 0);
        chk("wstrb", wstrb, 4'hF);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 0;

        run(32'h10, 32'h14, 32'h20, 8, 0, 1, 0);

        ar_hold_addr = 32'h30; ar_hold = 4; w_hold = 2;
        run(32'h30, 32'h34, 32'h24, 14, 0, 0, 0);
        chk("ar_stable", ar_bad, 0);
        ar_hold_addr = '1; ar_hold = 0; w_hold = 0;

        rerr_addr = 32'h14;
        run(32'h10, 32'h14, 32'h28, 5, 1, 0, 0);
        rerr_addr = '1;

`ifdef AXIL_MAC_ACCUM_EN
        @(negedge PCLK);
        acc_clr = 1;
        @(posedge PCLK); #1;
        acc_clr = 0;
        acc_u = '0; acc_s = '0;
        chk("acc_clr", {result, s_result}, 0);
`endif
        run(32'h40, 32'h44, 32'h2C, 8, 0, 0, 1);
        run(32'h40, 32'h44, 32'h2C, 8, 0, 0, 0);
        run(32'h40, 32'h44, 32'h2C, 8, 0, 0, 0);
`ifdef AXIL_MAC_ACCUM_EN
        chk("acc_wrap", result, 32'hFFFA_0003);
`endif

        aw_hold = 5; w_hold = 5;
        @(negedge PCLK);
        raddr_a = 32'h10; raddr_b = 32'h14; waddr = 32'h20; start = 1;
        @(posedge PCLK); #1;
        start = 0;
        n = 0;
        while (!awvalid && n < 50) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk("wr_reach", awvalid, 1);
        @(negedge PCLK);
        PRESET = 1;
        #1;
        chk("rst_mid_axi", {arvalid, rready, awvalid, wvalid, bready, busy}, 0);
        @(posedge PCLK); #1;
        chk("rst_mid_hold", {arvalid, rready, awvalid, wvalid, bready, busy}, 0);
        chk("rst_mid_res", {result, s_result}, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 0;
        aw_hold = 0; w_hold = 0;
        acc_u = '0; acc_s = '0;

        run(32'h10, 32'h14, 32'h20, 8, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
